reconfig_controller: RTL and testbench
======================================

// Module: reconfig_controller
// PURPOSE
//  Upstream stage of the datapath configurator. Accepts reconfiguration
//  requests carrying a dataflow ID (1=FIR128, 2=FIR64, 3=CONV).
//  Drains in-flight tokens from the shared datapath, then switches the
//  registered ID that drives the configurator's ID input. Holds input
//  traffic stalled until the new switch setting has settled.
// PARAMETERS
//  ID_W          8  width of dataflow ID (matches configurator ID input)
//  NUM_CFG       3  highest legal ID; legal IDs are 1..NUM_CFG
//  DEFAULT_ID    1  ID driven after reset
//  CNT_W         8  width of in-flight token counter
//  SETTLE_CYCLES 2  cycles stall is held after ID change; must be >=1
// PORTS
//  clock         in   1     single clock, all logic rising-edge
//  reset         in   1     synchronous, active-high
//  cfg_id_valid  in   1     reconfiguration request valid
//  cfg_id        in   ID_W  requested dataflow ID
//  cfg_id_ready  out  1     request accepted when valid&ready
//  cfg_done      out  1     1-cycle pulse: requested ID is active, traffic released
//  cfg_err       out  1     1-cycle pulse: illegal ID rejected
//  cfg_busy      out  1     high while state != RUN
//  in_fire       in   1     token entered datapath this cycle
//  out_fire      in   1     token left datapath this cycle
//  stall         out  1     forces datapath input ready low
//  ID            out  ID_W  registered ID to configurator
// BEHAVIOUR
//  Reset: state=RUN, ID=DEFAULT_ID, cnt=0, pending=0, settle=0.
//   Reset values: cfg_done=0, cfg_err=0, stall=0, cfg_busy=0, cfg_id_ready=1.
//   Reset mid-operation aborts any drain or settle with no cfg_done.
//  Counter: cnt_nxt = cnt + in_fire - out_fire.
//   in_fire and out_fire together leave cnt unchanged.
//   out_fire at cnt=0 is ignored (no underflow).
//   in_fire at cnt=all-ones is ignored (saturate).
//  Outputs: stall=1 in DRAIN/SETTLE, and in RUN when cnt is all-ones.
//   cfg_id_ready=1 only in RUN; cfg_busy = (state!=RUN).
//   All outputs are registered.
//  RUN: on an accepted request (valid&ready at cycle T):
//   cfg_id==0 or cfg_id>NUM_CFG: cfg_err=1 at T+1; stay RUN.
//   cfg_id==ID: cfg_done=1 at T+1; stay RUN; no stall.
//   otherwise: pending<=cfg_id; state=DRAIN at T+1, with stall=1 and busy=1.
//  DRAIN: wait for cnt_nxt==0.
//   Then ID<=pending, settle<=SETTLE_CYCLES, go to SETTLE.
//   The new ID is visible in the first SETTLE cycle.
//   Stray in_fire during DRAIN is still counted and extends the drain.
//  SETTLE: if settle==1, go to RUN; else settle<=settle-1.
//   On entering RUN: stall=0 and cfg_done=1 for exactly 1 cycle.
//  Requests in DRAIN/SETTLE are not accepted; the requester holds valid
//   and cfg_id stable until ready. Only one request is outstanding.
//  Latency with cnt=0 at accept: ID changes at T+2.
//   stall falls and cfg_done pulses at T+2+SETTLE_CYCLES.
// TESTING
//  1 Reset, no stimulus -> ID=1, stall=0, ready=1, done=err=busy=0.
//  2 cnt=0, request ID=3 at T -> stall=1 at T+1; ID=3 at T+2;
//     with SETTLE_CYCLES=2: done pulse and stall=0 at T+4.
//  3 Five in_fire then request ID=2; out_fire one per 3 cycles ->
//     ID stays 1 until the 5th out_fire; then ID=2 next cycle;
//     done 2 cycles later.
//  4 Request ID=0, then ID=4 -> cfg_err pulse 1 cycle after each;
//     ID, stall and state unchanged.
//  5 Request ID equal to current ID=1 -> done at T+1; stall never rises.
//     in_fire and out_fire in the same cycle -> cnt unchanged.
//  6 Reset asserted in DRAIN with cnt=4 -> next cycle ID=1, cnt=0,
//     stall=0, ready=1, no done pulse.
//     Also: valid held during SETTLE -> not accepted until RUN.

Source files
------------

// File: rtl/reconfig_controller.sv
// reconfig_controller: accepts dataflow reconfiguration requests, drains the
// shared datapath of in-flight tokens, switches the registered ID that feeds
// the configurator, and keeps input traffic stalled until the new setting
// has settled.
module reconfig_controller #(
   parameter int ID_W          = 8,
   parameter int NUM_CFG       = 3,
   parameter int DEFAULT_ID    = 1,
   parameter int CNT_W         = 8,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            cfg_id_valid,
   input  logic [ID_W-1:0] cfg_id,
   output logic            cfg_id_ready,
   output logic            cfg_done,
   output logic            cfg_err,
   output logic            cfg_busy,
   input  logic            in_fire,
   input  logic            out_fire,
   output logic            stall,
   output logic [ID_W-1:0] ID
);

   // Settle counter only needs to hold SETTLE_CYCLES.
   localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

   localparam logic [ID_W-1:0]  MAX_ID      = ID_W'(NUM_CFG);
   localparam logic [ID_W-1:0]  RESET_ID    = ID_W'(DEFAULT_ID);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [ID_W-1:0]  id_reg, id_next;
   logic [ID_W-1:0]  pending_reg, pending_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [SET_W-1:0] settle_reg, settle_next;
   logic             done_reg, done_next;
   logic             err_reg, err_next;
   logic             stall_reg, stall_next;
   logic             busy_reg, busy_next;
   logic             ready_reg, ready_next;
   logic             accept;

   assign accept = cfg_id_valid & ready_reg;

   // In-flight token count: simultaneous enter/leave cancel, never wraps.
   always_comb begin
      cnt_next = cnt_reg;
      case ({in_fire, out_fire})
         2'b10:   if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
         2'b01:   if (cnt_reg != '0)      cnt_next = cnt_reg - 1'b1;
         default: cnt_next = cnt_reg;
      endcase
   end

   // Next-state logic for the request / drain / settle sequence.
   always_comb begin
      state_next   = state_reg;
      id_next      = id_reg;
      pending_next = pending_reg;
      settle_next  = settle_reg;
      done_next    = 1'b0;
      err_next     = 1'b0;
      case (state_reg)
         RUN: begin
            if (accept) begin
               if (cfg_id == '0 || cfg_id > MAX_ID) begin
                  err_next = 1'b1;
               end else if (cfg_id == id_reg) begin
                  done_next = 1'b1;
               end else begin
                  pending_next = cfg_id;
                  state_next   = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Look at the post-update count so the last departing token
            // releases the switch in the same cycle it leaves.
            if (cnt_next == '0) begin
               id_next     = pending_reg;
               settle_next = SETTLE_INIT;
               state_next  = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_reg == SETTLE_LAST) begin
               state_next = RUN;
               done_next  = 1'b1;
            end else begin
               settle_next = settle_reg - 1'b1;
            end
         end
         default: state_next = RUN;
      endcase
   end

   // Output flags are derived from next state so they register with it.
   always_comb begin
      busy_next  = (state_next != RUN);
      ready_next = (state_next == RUN);
      stall_next = (state_next != RUN) || (cnt_next == CNT_MAX);
   end

   // State and registered outputs; reset aborts any sequence in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg   <= RUN;
         id_reg      <= RESET_ID;
         pending_reg <= '0;
         cnt_reg     <= '0;
         settle_reg  <= '0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
         stall_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         ready_reg   <= 1'b1;
      end else begin
         state_reg   <= state_next;
         id_reg      <= id_next;
         pending_reg <= pending_next;
         cnt_reg     <= cnt_next;
         settle_reg  <= settle_next;
         done_reg    <= done_next;
         err_reg     <= err_next;
         stall_reg   <= stall_next;
         busy_reg    <= busy_next;
         ready_reg   <= ready_next;
      end
   end

   assign cfg_id_ready = ready_reg;
   assign cfg_done     = done_reg;
   assign cfg_err      = err_reg;
   assign cfg_busy     = busy_reg;
   assign stall        = stall_reg;
   assign ID           = id_reg;

endmodule

// File: tb/tb_reconfig_controller.sv
// tb_reconfig_controller: directed vectors with hand-computed expectations
// for reconfig_controller (default parameters, SETTLE_CYCLES=2).
module tb_reconfig_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic       cfg_id_valid;
   logic [7:0] cfg_id;
   logic       cfg_id_ready;
   logic       cfg_done;
   logic       cfg_err;
   logic       cfg_busy;
   logic       in_fire;
   logic       out_fire;
   logic       stall;
   logic [7:0] ID;

   int checks   = 0;
   int failures = 0;

   reconfig_controller dut (
      .clock        (clock),
      .reset        (reset),
      .cfg_id_valid (cfg_id_valid),
      .cfg_id       (cfg_id),
      .cfg_id_ready (cfg_id_ready),
      .cfg_done     (cfg_done),
      .cfg_err      (cfg_err),
      .cfg_busy     (cfg_busy),
      .in_fire      (in_fire),
      .out_fire     (out_fire),
      .stall        (stall),
      .ID           (ID)
   );

   always #5 clock = ~clock;

   // Advance one cycle; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag, input logic [7:0] exp_id);
      check({tag, "_id"},    ID,           exp_id);
      check({tag, "_stall"}, stall,        0);
      check({tag, "_ready"}, cfg_id_ready, 1);
      check({tag, "_busy"},  cfg_busy,     0);
      check({tag, "_done"},  cfg_done,     0);
      check({tag, "_err"},   cfg_err,      0);
   endtask

   // Present a request for one cycle (caller knows ready is high).
   task automatic request(input logic [7:0] id);
      $display("request id=%0d at %0t", id, $time);
      cfg_id_valid = 1'b1;
      cfg_id       = id;
      step();
      cfg_id_valid = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      cfg_id_valid = 1'b0;
      cfg_id       = '0;
      in_fire      = 1'b0;
      out_fire     = 1'b0;
      step();
      step();
      reset = 1'b0;

      // 1: reset state
      check_idle("reset", 8'd1);
      step();
      check_idle("reset_hold", 8'd1);

      // 5: same ID -> immediate done, no stall
      request(8'd1);
      check("same_done",  cfg_done, 1);
      check("same_stall", stall,    0);
      check("same_busy",  cfg_busy, 0);
      check("same_id",    ID,       1);
      step();
      check("same_done_clr", cfg_done, 0);
      check("same_stall2",   stall,    0);

      // 4: illegal IDs -> err pulse, nothing else moves
      request(8'd0);
      check("err0_err",   cfg_err,  1);
      check("err0_stall", stall,    0);
      check("err0_busy",  cfg_busy, 0);
      check("err0_done",  cfg_done, 0);
      step();
      check("err0_clr",   cfg_err,  0);
      request(8'd4);
      check("err4_err",   cfg_err,  1);
      check("err4_ready", cfg_id_ready, 1);
      step();
      check_idle("err4_after", 8'd1);

      // 3: five tokens in, one simultaneous in+out, then request ID=2
      in_fire = 1'b1;
      for (int i = 0; i < 5; i++) step();
      out_fire = 1'b1;
      step();
      in_fire  = 1'b0;
      out_fire = 1'b0;
      request(8'd2);
      check("drain_stall", stall,        1);
      check("drain_busy",  cfg_busy,     1);
      check("drain_ready", cfg_id_ready, 0);
      for (int k = 1; k <= 5; k++) begin
         step();
         step();
         out_fire = 1'b1;
         step();
         out_fire = 1'b0;
         if (k < 5) check($sformatf("drain_id_k%0d", k), ID, 1);
      end
      check("switch_id",    ID,       2);
      check("switch_stall", stall,    1);
      check("switch_done",  cfg_done, 0);
      step();
      check("settle_done", cfg_done, 0);
      check("settle_busy", cfg_busy, 1);
      step();
      check("rel_done",  cfg_done,     1);
      check("rel_stall", stall,        0);
      check("rel_ready", cfg_id_ready, 1);
      step();
      check("rel_done_clr", cfg_done, 0);

      // out_fire at cnt=0 must not underflow
      out_fire = 1'b1;
      step();
      out_fire = 1'b0;
      in_fire  = 1'b1;
      step();
      in_fire  = 1'b0;
      request(8'd1);
      check("uf_busy", cfg_busy, 1);
      step();
      check("uf_wait_id", ID, 2);
      out_fire = 1'b1;
      step();
      out_fire = 1'b0;
      check("uf_switch_id", ID, 1);
      step();
      step();
      check("uf_done", cfg_done, 1);
      step();

      // 2: cnt=0, request ID=3 -> exact latency
      request(8'd3);
      check("lat_t1_stall", stall, 1);
      check("lat_t1_id",    ID,    1);
      step();
      check("lat_t2_id",    ID,    3);
      check("lat_t2_stall", stall, 1);
      step();
      check("lat_t3_done",  cfg_done, 0);
      check("lat_t3_stall", stall,    1);
      step();
      check("lat_t4_done",  cfg_done, 1);
      check("lat_t4_stall", stall,    0);
      check("lat_t4_busy",  cfg_busy, 0);
      step();
      check("lat_t5_done",  cfg_done, 0);

      // 6: reset in DRAIN with cnt=4
      in_fire = 1'b1;
      for (int i = 0; i < 4; i++) step();
      in_fire = 1'b0;
      request(8'd2);
      check("rst_drain_busy", cfg_busy, 1);
      step();
      check("rst_drain_id", ID, 3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_idle("rst_mid", 8'd1);

      // cnt cleared by reset: request ID=2 switches at T+2; second request
      // held valid from T+1 is only accepted once back in RUN
      request(8'd2);
      $display("request id=3 held from %0t", $time);
      cfg_id_valid = 1'b1;
      cfg_id       = 8'd3;
      check("hold_t1_ready", cfg_id_ready, 0);
      step();
      check("hold_t2_id",    ID,           2);
      check("hold_t2_ready", cfg_id_ready, 0);
      step();
      check("hold_t3_busy",  cfg_busy,     1);
      step();
      check("hold_t4_done",  cfg_done,     1);
      check("hold_t4_ready", cfg_id_ready, 1);
      check("hold_t4_id",    ID,           2);
      step();
      cfg_id_valid = 1'b0;
      check("hold_t5_busy",  cfg_busy, 1);
      check("hold_t5_done",  cfg_done, 0);
      check("hold_t5_stall", stall,    1);
      step();
      check("hold_t6_id", ID, 3);
      step();
      step();
      check("hold_t8_done", cfg_done, 1);
      step();

      // Counter saturation: stall in RUN when full
      in_fire = 1'b1;
      for (int i = 0; i < 254; i++) step();
      check("sat_254_stall", stall, 0);
      step();
      check("sat_255_stall", stall,        1);
      check("sat_255_ready", cfg_id_ready, 1);
      check("sat_255_busy",  cfg_busy,     0);
      step();
      check("sat_extra_stall", stall, 1);
      in_fire  = 1'b0;
      out_fire = 1'b1;
      step();
      out_fire = 1'b0;
      check("sat_out_stall", stall, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
